// File: rtl/jtdd_snd_pkg.sv
// Shared types and constants for the jtdd sound mixer: frame FSM states,
// gain fixed-point format and accumulator sizing.
package jtdd_snd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } state_t;

  localparam int         GAIN_FRAC  = 4;
  localparam logic [7:0] GAIN_UNITY = 8'h10;

  // W-bit sample times 9-bit zero-extended gain, plus headroom for CH terms.
  function automatic int acc_width(input int w, input int ch);
    return w + 9 + $clog2(ch);
  endfunction

endpackage

// File: rtl/jtdd_snd_sat.sv
// Drops the gain fraction with an arithmetic shift, then clamps the result
// into OUT_W signed bits and flags whether clamping happened.
module jtdd_snd_sat
  import jtdd_snd_pkg::*;
#(
  parameter int IN_W  = 27,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic        [OUT_W-1:0] o_dout,
  output logic                    o_clip
);

  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] w_shr;

  assign w_shr = i_din >>> GAIN_FRAC;

  always_comb begin
    o_dout = w_shr[OUT_W-1:0];
    o_clip = 1'b0;
    if (w_shr > MAXV) begin
      o_dout = MAXV[OUT_W-1:0];
      o_clip = 1'b1;
    end else if (w_shr < MINV) begin
      o_dout = MINV[OUT_W-1:0];
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/jtdd_snd_mix.sv
// Stereo mixer: CH gain-scaled channels summed by one shared multiplier pair
// over CH cycles per frame, then shifted, saturated and registered.
module jtdd_snd_mix
  import jtdd_snd_pkg::*;
#(
  parameter int         CH       = 4,
  parameter int         W        = 16,
  parameter logic [7:0] GAIN_RST = GAIN_UNITY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [CH*W-1:0] din_l,
  input  logic [CH*W-1:0] din_r,
  input  logic          gain_we,
  input  logic [3:0]    gain_addr,
  input  logic [7:0]    gain_din,
  input  logic          mute,
  output logic [W-1:0]  left,
  output logic [W-1:0]  right,
  output logic          sample,
  output logic          clip,
  output logic          overrun,
  output logic          busy,
  output state_t        dbg_state
);

  localparam int IW = $clog2(CH);
  localparam int PW = W + 9;
  localparam int AW = acc_width(W, CH);

  logic [7:0]           r_gain  [CH];
  logic [7:0]           r_gsnap [CH];
  logic [W-1:0]         r_snap_l[CH];
  logic [W-1:0]         r_snap_r[CH];
  logic signed [AW-1:0] r_acc_l, r_acc_r;
  logic [IW-1:0]        r_idx;
  state_t               r_state;

  logic signed [PW-1:0] w_a_l, w_a_r, w_b, w_prod_l, w_prod_r;
  logic [W-1:0]         w_sat_l, w_sat_r;
  logic                 w_clip_l, w_clip_r;

  assign dbg_state = r_state;

  // Operands pre-extended to the product width so the truncated product is exact.
  assign w_a_l    = {{9{r_snap_l[r_idx][W-1]}}, r_snap_l[r_idx]};
  assign w_a_r    = {{9{r_snap_r[r_idx][W-1]}}, r_snap_r[r_idx]};
  assign w_b      = {{(W+1){1'b0}}, r_gsnap[r_idx]};
  assign w_prod_l = w_a_l * w_b;
  assign w_prod_r = w_a_r * w_b;

  jtdd_snd_sat #(.IN_W(AW), .OUT_W(W)) u_sat_l (
    .i_din (r_acc_l),
    .o_dout(w_sat_l),
    .o_clip(w_clip_l)
  );

  jtdd_snd_sat #(.IN_W(AW), .OUT_W(W)) u_sat_r (
    .i_din (r_acc_r),
    .o_dout(w_sat_r),
    .o_clip(w_clip_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) r_gain[k] <= GAIN_RST;
    end else if (gain_we && ({1'b0, gain_addr} < 5'(CH))) begin
      r_gain[gain_addr[IW-1:0]] <= gain_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      left    <= '0;
      right   <= '0;
      sample  <= 1'b0;
      clip    <= 1'b0;
      overrun <= 1'b0;
      busy    <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        r_gsnap[k]  <= GAIN_RST;
        r_snap_l[k] <= '0;
        r_snap_r[k] <= '0;
      end
    end else begin
      sample  <= 1'b0;
      overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cen) begin
            for (int k = 0; k < CH; k++) begin
              r_gsnap[k]  <= r_gain[k];
              r_snap_l[k] <= din_l[k*W +: W];
              r_snap_r[k] <= din_r[k*W +: W];
            end
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= ACC;
          end
        end
        ACC: begin
          overrun <= cen;
          r_acc_l <= r_acc_l + {{(AW-PW){w_prod_l[PW-1]}}, w_prod_l};
          r_acc_r <= r_acc_r + {{(AW-PW){w_prod_r[PW-1]}}, w_prod_r};
          if (r_idx == IW'(CH-1)) begin
            r_idx   <= '0;
            r_state <= SAT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        SAT: begin
          overrun <= cen;
          left    <= mute ? '0 : w_sat_l;
          right   <= mute ? '0 : w_sat_r;
          clip    <= mute ? 1'b0 : (w_clip_l | w_clip_r);
          sample  <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/jtdd_snd_mix.md
# jtdd_snd_mix

Parametrised stereo sound mixer for the sound subsystem. It replaces the fixed "sum FM plus ADPCM and shift" output stage with CH stereo channels, each with a CPU-programmable gain. The channels are combined by a time-multiplexed multiply-accumulate, then saturated and output once per sample enable. It sits between the sound sources (FM, ADPCM channels, future PCM) and the board-level audio output, and is written by the sound CPU through its own chip select.

## Interface
Parameters:
- CH, 4, number of stereo input channels (2..16).
- W, 16, sample width of inputs and outputs, signed two's complement.
- GAIN_RST, 8'h10, reset value of every gain register (unsigned 4.4, 8'h10 = unity).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cen  in  1  sample enable; a one-cycle pulse starts one mix frame.
- din_l  in  CH*W  left inputs; channel k occupies bits [k*W +: W].
- din_r  in  CH*W  right inputs; same packing as din_l.
- gain_we  in  1  gain register write strobe.
- gain_addr  in  4  channel index for the write.
- gain_din  in  8  gain value, unsigned 4.4.
- mute  in  1  forces the next results to zero.
- left  out  W  mixed left output, registered.
- right  out  W  mixed right output, registered.
- sample  out  1  one-cycle pulse when left/right update.
- clip  out  1  high while the current result was saturated on either side.
- overrun  out  1  one-cycle pulse when cen is ignored.
- busy  out  1  high while a frame is in progress.

## Operation
- Gain bank: CH registers of 8 bits, reset to GAIN_RST.
  - A write with gain_we=1 updates gain[gain_addr] on the next edge.
  - Writes with gain_addr >= CH are ignored.
- Frame FSM, states IDLE, ACC, SAT:
  - IDLE with cen=1: snapshot din_l, din_r and all gains; clear both accumulators; idx=0; go to ACC.
  - IDLE with cen=0: stay in IDLE.
  - ACC: each cycle, acc_l += snap_l[idx] * {1'b0,gain[idx]} and likewise for right; idx++. After idx = CH-1, go to SAT.
  - SAT: register the results, go to IDLE.
- Arithmetic:
  - Product width is W+9 bits; accumulator width is W+9+clog2(CH). No intermediate truncation.
  - Result = acc >>> 4 (arithmetic shift), then saturated to [-2^(W-1), 2^(W-1)-1].
  - clip = 1 if either side saturated.
- If mute=1 during SAT, left and right load 0 and clip loads 0. sample still pulses.
- cen while busy (ACC or SAT): the pulse is ignored, overrun pulses for one cycle, and the frame in progress is unaffected.
- One multiplier pair (left and right) is shared across channels.

## Timing
- Reset values: left=0, right=0, sample=0, clip=0, overrun=0, busy=0, FSM in IDLE, idx=0, accumulators=0, gains=GAIN_RST.
- Counting the cen cycle as cycle 0:
  - ACC occupies cycles 1..CH.
  - SAT occurs in cycle CH+1.
  - left, right and clip change, and sample=1, in cycle CH+2.
- busy is high in cycles 1..CH+1.
- A cen in cycle CH+2 is accepted, so the minimum cen period is CH+2 cycles.
- Simultaneous gain write and accepted cen: the snapshot takes the old gain value; the new value applies from the next frame.
- A gain write during ACC or SAT does not affect the current frame.
- left, right and clip hold their values between sample pulses.
- Asynchronous rst mid-frame aborts the frame and restores all reset values; no sample pulse is produced for the aborted frame.

## Structure
- Package jtdd_snd_pkg holds:
  - the FSM state enum (IDLE, ACC, SAT);
  - GAIN_FRAC=4 and GAIN_UNITY=8'h10;
  - a function for the accumulator width.
- Sub-module jtdd_snd_sat: parametrised (IN_W, OUT_W) arithmetic shift-and-saturate with a clip flag. It is instantiated once per side.

## Test plan
- Reset defaults, CH=4, W=16, all gains unity; inputs L={1000,2000,-500,0}; cen pulse -> sample in cycle 6, left=2500, clip=0, busy high in cycles 1..5.
- Gain scaling: gain[1]=8'h08, gain[2]=8'h20, same inputs -> left = 1000+1000-1000+0 = 1000.
- Saturation: all inputs 16'h7000, gains 8'hF0 -> left=32767, right=32767, clip=1. All inputs 16'h9000 (negative) -> left=-32768.
- Overrun and write ordering:
  - cen in cycle 3 -> overrun pulse, single sample in cycle 6.
  - Gain write coincident with cen -> old gain is used; new gain appears in the next frame's result.
- Mute, and write to gain_addr=7 with CH=4 -> left=right=0 with a sample pulse; gain bank unchanged.
- rst asserted in cycle 3 -> no sample pulse, all outputs 0, gains back to 8'h10; the next cen produces a correct frame.
